polyveck_use_hint_stream: RTL and testbench

- Streaming, pipelined UseHint engine for a full polynomial vector: K polynomials of N coefficients, LANES coefficients per beat.
- Input is an r coefficient stream plus a hint-bit stream. Output is the high-bits w1 stream.
- Replaces the fully combinational vector form in the verify datapath, cutting area by time-multiplexing over LANES lanes.
- Supports both Dilithium gamma2 modes through a parameter.

---
 rtl/polyveck_use_hint_stream_if.sv | 29 ++
 rtl/polyveck_use_hint_stream.sv | 157 +++++++++++++++
 tb/tb_polyveck_use_hint_stream.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/polyveck_use_hint_stream_if.sv
// Beat-level stream bundle for the UseHint engine: r/hint beats in, w1 beats plus sideband out.
// The master drives the input beat and the downstream ready; the slave is the engine.
interface polyveck_use_hint_stream_if #(
  parameter int LANES   = 4,
  parameter int COEFF_W = 32,
  parameter int PIDX_W  = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*COEFF_W-1:0]   in_coef;
  logic [LANES-1:0]           in_hint;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*COEFF_W-1:0]   out_coef;
  logic [PIDX_W-1:0]          out_poly_idx;
  logic                       out_last_poly;
  logic                       out_last;
  logic [LANES-1:0]           out_oor;

  modport master (
    output in_valid, in_coef, in_hint, out_ready,
    input  in_ready, out_valid, out_coef, out_poly_idx, out_last_poly, out_last, out_oor
  );

  modport slave (
    input  in_valid, in_coef, in_hint, out_ready,
    output in_ready, out_valid, out_coef, out_poly_idx, out_last_poly, out_last, out_oor
  );
endinterface

// File: rtl/polyveck_use_hint_stream.sv
// Two-stage streaming Decompose + UseHint over a K x N coefficient vector, LANES per beat.
// Stage 1 holds (a1, a0, hint); stage 2 holds w1 and the polynomial sideband.
module polyveck_use_hint_stream #(
  parameter int K           = 6,
  parameter int N           = 256,
  parameter int LANES       = 4,
  parameter int COEFF_W     = 32,
  parameter int GAMMA2_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  polyveck_use_hint_stream_if.slave  bus
);
  localparam int BEATS   = N / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PIDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int Q       = 8380417;
  localparam int GAMMA2  = (GAMMA2_MODE != 0) ? 95232 : 261888;
  localparam int TWO_G2  = 2 * GAMMA2;
  localparam logic signed [COEFF_W-1:0] Q_C    = COEFF_W'(Q);
  localparam logic signed [31:0]        Q_S    = 32'(Q);
  localparam logic signed [31:0]        HALF_Q = 32'((Q - 1) / 2);

  logic adv;
  logic accept;

  logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
  logic [PIDX_W-1:0] polyCnt_q, polyCnt_d;
  logic              lastBeat;
  logic              lastVec;

  logic [LANES-1:0]            oor_d;
  logic [LANES-1:0][5:0]       a1_d;
  logic [LANES-1:0][19:0]      a0_d;
  logic [LANES*COEFF_W-1:0]    outCoef_d;

  logic                        s1Valid_q;
  logic [LANES-1:0][5:0]       s1A1_q;
  logic [LANES-1:0][19:0]      s1A0_q;
  logic [LANES-1:0]            s1Hint_q;
  logic [LANES-1:0]            s1Oor_q;
  logic [PIDX_W-1:0]           s1PolyIdx_q;
  logic                        s1LastPoly_q;
  logic                        s1Last_q;

  logic                        outValid_q;
  logic [LANES*COEFF_W-1:0]    outCoef_q;
  logic [PIDX_W-1:0]           outPolyIdx_q;
  logic                        outLastPoly_q;
  logic                        outLast_q;
  logic [LANES-1:0]            outOor_q;

  assign adv          = !outValid_q || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  assign lastBeat = (beatCnt_q == BEAT_W'(BEATS - 1));
  assign lastVec  = lastBeat && (polyCnt_q == PIDX_W'(K - 1));

  always_comb begin
    beatCnt_d = beatCnt_q;
    polyCnt_d = polyCnt_q;
    if (accept) begin
      beatCnt_d = lastBeat ? '0 : beatCnt_q + BEAT_W'(1);
      if (lastBeat) begin
        polyCnt_d = (polyCnt_q == PIDX_W'(K - 1)) ? '0 : polyCnt_q + PIDX_W'(1);
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [COEFF_W-1:0] r;
    logic [22:0]               rv;
    logic [31:0]               t;
    logic [5:0]                a1Pre;
    logic [5:0]                a1;
    logic signed [31:0]        a0Raw;
    logic signed [31:0]        a0Adj;
    logic [5:0]                a1s;
    logic [5:0]                up;
    logic [5:0]                dn;
    logic [5:0]                w1;

    assign r         = bus.in_coef[COEFF_W*j +: COEFF_W];
    assign oor_d[j]  = r[COEFF_W-1] || (r >= Q_C);
    assign rv        = oor_d[j] ? 23'd0 : r[22:0];

    // Reciprocal-multiply rounding; the top quotient (m) folds to 0, which is the q-1 corner.
    assign t     = (32'(rv) + 32'd127) >> 7;
    assign a1Pre = (GAMMA2_MODE != 0) ? 6'((t * 32'd11275 + 32'd8388608) >> 24)
                                      : 6'((t * 32'd1025 + 32'd2097152) >> 22);
    assign a1    = (GAMMA2_MODE != 0) ? ((a1Pre > 6'd43) ? 6'd0 : a1Pre)
                                      : (a1Pre & 6'd15);
    assign a0Raw = $signed(32'(rv) - 32'(a1) * 32'(TWO_G2));
    assign a0Adj = (a0Raw > HALF_Q) ? (a0Raw - Q_S) : a0Raw;

    assign a1_d[j] = a1;
    assign a0_d[j] = 20'(a0Adj);

    assign a1s = s1A1_q[j];
    assign up  = (GAMMA2_MODE != 0) ? ((a1s == 6'd43) ? 6'd0 : a1s + 6'd1)
                                    : ((a1s + 6'd1) & 6'd15);
    assign dn  = (GAMMA2_MODE != 0) ? ((a1s == 6'd0) ? 6'd43 : a1s - 6'd1)
                                    : ((a1s - 6'd1) & 6'd15);
    assign w1  = !s1Hint_q[j] ? a1s : (($signed(s1A0_q[j]) > 20'sd0) ? up : dn);

    assign outCoef_d[COEFF_W*j +: COEFF_W] = COEFF_W'(w1);
  end

  // Both stages move together on adv, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beatCnt_q     <= '0;
      polyCnt_q     <= '0;
      s1Valid_q     <= 1'b0;
      s1A1_q        <= '0;
      s1A0_q        <= '0;
      s1Hint_q      <= '0;
      s1Oor_q       <= '0;
      s1PolyIdx_q   <= '0;
      s1LastPoly_q  <= 1'b0;
      s1Last_q      <= 1'b0;
      outValid_q    <= 1'b0;
      outCoef_q     <= '0;
      outPolyIdx_q  <= '0;
      outLastPoly_q <= 1'b0;
      outLast_q     <= 1'b0;
      outOor_q      <= '0;
    end else begin
      beatCnt_q <= beatCnt_d;
      polyCnt_q <= polyCnt_d;
      if (adv) begin
        s1Valid_q     <= bus.in_valid;
        s1A1_q        <= a1_d;
        s1A0_q        <= a0_d;
        s1Hint_q      <= bus.in_hint;
        s1Oor_q       <= oor_d;
        s1PolyIdx_q   <= polyCnt_q;
        s1LastPoly_q  <= lastBeat;
        s1Last_q      <= lastVec;
        outValid_q    <= s1Valid_q;
        outCoef_q     <= outCoef_d;
        outPolyIdx_q  <= s1PolyIdx_q;
        outLastPoly_q <= s1LastPoly_q;
        outLast_q     <= s1Last_q;
        outOor_q      <= s1Oor_q;
      end
    end
  end

  assign bus.out_valid     = outValid_q;
  assign bus.out_coef      = outCoef_q;
  assign bus.out_poly_idx  = outPolyIdx_q;
  assign bus.out_last_poly = outLastPoly_q;
  assign bus.out_last      = outLast_q;
  assign bus.out_oor       = outOor_q;
endmodule

// File: tb/tb_polyveck_use_hint_stream.sv
// Scoreboard bench: drives both gamma2 modes with one stream and checks every emitted beat
// against a direct Decompose/UseHint model, plus directed latency, reset and out-of-range cases.
module tb_polyveck_use_hint_stream;
  localparam int K       = 6;
  localparam int N       = 256;
  localparam int LANES   = 4;
  localparam int COEFF_W = 32;
  localparam int PIDX_W  = 3;
  localparam int BEATS   = N / LANES;
  localparam int Q       = 8380417;
  localparam int W       = LANES * COEFF_W;

  typedef struct {
    logic [W-1:0]       coef0;
    logic [W-1:0]       coef1;
    logic [W-1:0]       mask;
    logic [LANES-1:0]   oor;
    logic [PIDX_W-1:0]  idx;
    logic               lastPoly;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   mBeat = 0;
  int   mPoly = 0;
  bit   randReady = 0;
  bit   randValid = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  polyveck_use_hint_stream_if #(.LANES(LANES), .COEFF_W(COEFF_W), .PIDX_W(PIDX_W)) bus0 ();
  polyveck_use_hint_stream_if #(.LANES(LANES), .COEFF_W(COEFF_W), .PIDX_W(PIDX_W)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_coef   = bus0.in_coef;
  assign bus1.in_hint   = bus0.in_hint;
  assign bus1.out_ready = bus0.out_ready;

  polyveck_use_hint_stream #(.K(K), .N(N), .LANES(LANES), .COEFF_W(COEFF_W), .GAMMA2_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  polyveck_use_hint_stream #(.K(K), .N(N), .LANES(LANES), .COEFF_W(COEFF_W), .GAMMA2_MODE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic int useHintModel(int r, bit h, int mode);
    int g2 = (mode == 1) ? 95232 : 261888;
    int m  = (mode == 1) ? 44 : 16;
    int a0;
    int a1;
    a0 = r % (2 * g2);
    if (a0 > g2) a0 -= 2 * g2;
    if (r - a0 == Q - 1) begin
      a1 = 0;
      a0 = a0 - 1;
    end else begin
      a1 = (r - a0) / (2 * g2);
    end
    if (!h) return a1;
    if (a0 > 0) return (a1 + 1) % m;
    return (a1 + m - 1) % m;
  endfunction

  function automatic exp_t buildExp(logic [W-1:0] coef, logic [LANES-1:0] hint, int beat, int poly);
    exp_t x;
    int   r;
    x.coef0 = '0;
    x.coef1 = '0;
    x.mask  = '0;
    x.oor   = '0;
    for (int j = 0; j < LANES; j++) begin
      r = $signed(coef[COEFF_W*j +: COEFF_W]);
      if (r < 0 || r >= Q) begin
        x.oor[j] = 1'b1;
      end else begin
        x.mask[COEFF_W*j +: COEFF_W]  = '1;
        x.coef0[COEFF_W*j +: COEFF_W] = 32'(useHintModel(r, hint[j], 0));
        x.coef1[COEFF_W*j +: COEFF_W] = 32'(useHintModel(r, hint[j], 1));
      end
    end
    x.idx      = PIDX_W'(poly);
    x.lastPoly = (beat == BEATS - 1);
    x.last     = (beat == BEATS - 1) && (poly == K - 1);
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: compare the head beat every cycle it is presented, retire it on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mBeat = 0;
      mPoly = 0;
    end else begin
      if (bus0.out_valid) begin
        checkOutput("pending_beat", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          e = sb[0];
          checkOutput("m0_coef", bus0.out_coef & e.mask, e.coef0 & e.mask);
          checkOutput("m0_oor", W'(bus0.out_oor), W'(e.oor));
          checkOutput("poly_idx", W'(bus0.out_poly_idx), W'(e.idx));
          checkOutput("last_poly", W'(bus0.out_last_poly), W'(e.lastPoly));
          checkOutput("last", W'(bus0.out_last), W'(e.last));
          checkOutput("m1_valid", W'(bus1.out_valid), W'(1));
          checkOutput("m1_coef", bus1.out_coef & e.mask, e.coef1 & e.mask);
          if (bus0.out_ready) void'(sb.pop_front());
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        sb.push_back(buildExp(bus0.in_coef, bus0.in_hint, mBeat, mPoly));
        if (mBeat == BEATS - 1) begin
          mBeat = 0;
          mPoly = (mPoly == K - 1) ? 0 : mPoly + 1;
        end else begin
          mBeat++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) bus0.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [W-1:0] coef, input logic [LANES-1:0] hint);
    bit acc = 0;
    int guard = 0;
    if (randValid) repeat ($urandom_range(0, 2)) tick();
    bus0.in_valid = 1'b1;
    bus0.in_coef  = coef;
    bus0.in_hint  = hint;
    do begin
      @(negedge clk);
      acc = bus0.in_ready && rst_n;
      tick();
      guard++;
    end while (!acc && guard < 200);
    if (!acc) checkOutput("accept_timeout", W'(acc), W'(1));
    bus0.in_valid = 1'b0;
  endtask

  task automatic sendRandom(input int beats);
    logic [W-1:0] c;
    for (int b = 0; b < beats; b++) begin
      for (int j = 0; j < LANES; j++) c[COEFF_W*j +: COEFF_W] = 32'($urandom_range(0, Q - 1));
      applyStimulus(c, LANES'($urandom));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("drain_empty", W'(sb.size()), W'(0));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_coef   = '0;
    bus0.in_hint   = '0;
    bus0.out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("rst_out_valid", W'(bus0.out_valid), W'(0));
    checkOutput("rst_out_coef", bus0.out_coef, W'(0));
    checkOutput("rst_poly_idx", W'(bus0.out_poly_idx), W'(0));
    checkOutput("rst_last_poly", W'(bus0.out_last_poly), W'(0));
    checkOutput("rst_last", W'(bus0.out_last), W'(0));
    checkOutput("rst_oor", W'(bus0.out_oor), W'(0));
    checkOutput("rst_in_ready", W'(bus0.in_ready), W'(1));
    rst_n = 1'b1;

    $display("[TB] directed mode 0 beat and latency");
    applyStimulus({32'd8380416, 32'd523777, 32'd523776, 32'd0}, 4'b1101);
    checkOutput("lat_first_cycle", W'(bus0.out_valid), W'(0));
    tick();
    checkOutput("lat_second_cycle", W'(bus0.out_valid), W'(1));
    checkOutput("m0_directed", bus0.out_coef, {32'd15, 32'd2, 32'd1, 32'd15});
    tick();

    $display("[TB] directed mode 1 beat");
    applyStimulus({32'd95232, 32'd8189953, 32'd8189953, 32'd0}, 4'b1011);
    tick();
    checkOutput("m1_directed", bus1.out_coef, {32'd1, 32'd43, 32'd0, 32'd43});

    applyStimulus({32'd8380415, 32'd8118529, 32'd261888, 32'd261889}, 4'b1111);

    $display("[TB] out-of-range lanes");
    applyStimulus({32'd100, 32'hFFFF_FFFF, 32'd200000, 32'd8380417}, 4'b0110);
    tick();
    checkOutput("oor_lanes", W'(bus0.out_oor), W'(4'b0101));
    drain();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    $display("[TB] two back-to-back vectors, no stall");
    sendRandom(2 * K * BEATS);
    drain();

    $display("[TB] three vectors with random stalls and gaps");
    randReady = 1;
    randValid = 1;
    sendRandom(3 * K * BEATS);
    drain();
    randReady = 0;
    randValid = 0;
    bus0.out_ready = 1'b1;

    $display("[TB] reset in the middle of a vector");
    sendRandom(101);
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid_valid", W'(bus0.out_valid), W'(0));
    checkOutput("rst_mid_last_poly", W'(bus0.out_last_poly), W'(0));
    rst_n = 1'b1;
    sendRandom(BEATS + 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
